rs_age_ordered: RTL and testbench
=================================

Name: rs_age_ordered

Overview:
- Parametrised successor to the single-ALU reservation station.
- Holds dispatched ALU-class instructions until both operands are ready, then issues one per cycle to the ALU through a registered valid/ready output.
- Generalised in depth, tag width and number of result-broadcast (CDB) channels.
- Adds a dispatch ready handshake, issue back-pressure and an occupancy count.
- Sits between dispatcher and ALU; snoops all CDB channels (ALU, LSB, future units); flushed by ROB mispredict.

Parameters:
- RS_DEPTH, 16, number of entries (power of two, 2..32).
- TAG_W, 5, ROB tag width. Tag 0 means "value present".
- DATA_W, 32, operand/imm/pc width.
- OP_W, 7, opcode width.
- CDB_N, 2, number of result-broadcast channels.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rdy  in  1  global enable; when 0, no state changes (except reset)
- wrong_commit  in  1  flush from ROB
- cdb_valid  in  CDB_N  per-channel result valid
- cdb_tag  in  CDB_N*TAG_W  per-channel ROB tag, channel k at [k*TAG_W +: TAG_W]
- cdb_data  in  CDB_N*DATA_W  per-channel result
- disp_valid  in  1  dispatch request
- disp_ready  out  1  combinational: at least one free entry and not wrong_commit
- disp_op  in  OP_W  opcode
- disp_pc  in  DATA_W  pc
- disp_imm  in  DATA_W  immediate
- disp_vi, disp_vj  in  DATA_W  operand values
- disp_qi, disp_qj  in  TAG_W  operand producer tags
- disp_rd  in  TAG_W  destination ROB tag
- iss_valid  out  1  registered issue valid
- iss_ready  in  1  ALU accepts
- iss_op  out  OP_W
- iss_vi, iss_vj, iss_imm, iss_pc  out  DATA_W
- iss_rd  out  TAG_W
- rs_count  out  $clog2(RS_DEPTH)+1  busy entries, registered

Behaviour:
- Reset (rst_n=0 at posedge): all busy=0, all Q=0, iss_valid=0, all iss_* = 0, rs_count=0, age matrix cleared. Reset has priority over wrong_commit and rdy.
- Flush (wrong_commit=1, rst_n=1): same clearing as reset. Same-cycle dispatch and issue are dropped. disp_ready=0 that cycle.
- All remaining actions require rdy=1.
- Wake-up: for every busy entry and each channel k with cdb_valid[k] and a nonzero cdb_tag[k] equal to Qi (or Qj), write Vi (Vj) with the data and clear the tag. If several channels match the same tag, the lowest k wins.
- Dispatch bypass: if disp_qi/disp_qj matches a valid CDB tag in the same cycle, the captured V is the CDB data and Q is 0 (lowest k wins).
- Dispatch (disp_valid && disp_ready): write the lowest-index free entry, computed from registered busy. An entry freed by issue this cycle is not reusable until next cycle.
- Ready: busy && Qi==0 && Qj==0, evaluated on registered state. An entry woken at edge t is selectable in the cycle after t.
- Minimum latency: dispatch with ready operands at edge t gives iss_valid=1 after edge t+1.
- Output register loads when !iss_valid || iss_ready.
  - If a ready entry exists: copy it to iss_*, set iss_valid=1, clear that entry's busy.
  - Otherwise: iss_valid=0; iss_* hold their previous values.
- While iss_valid && !iss_ready, iss_* are stable and no entry is freed.
- rs_count next = rs_count + dispatched − issued. Simultaneous dispatch and issue leave it unchanged. It never exceeds RS_DEPTH.
- Full: disp_ready=0 when rs_count==RS_DEPTH. A dispatch attempt while full is ignored; no state change.
- Tag width: a nonzero tag never matches 0; CDB tag 0 is ignored.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined:
  - Maintain a RS_DEPTH×RS_DEPTH age matrix. On dispatch into e, set older[j][e]=busy[j] and older[e][*]=0.
  - Select the ready entry with no ready, older, busy entry; issue is oldest-ready-first.
  - Flush/reset clears the matrix.
- Undefined: no matrix; select is the lowest-index ready entry.

Decomposition:
- Shared package/header (const_def.v): RS_DEPTH, TAG_W, DATA_W, OP_W, CDB_N defaults; TAG_NONE=0.
- One sub-module, rs_select: combinational priority/age picker. Inputs: ready vector and age matrix. Outputs: one-hot grant and any_ready.

Test Plan:
- Reset, then dispatch op=7'h33 vi=5 vj=7 qi=qj=0 rd=3 at edge 1 → iss_valid=1 after edge 2, iss_vi=5, iss_vj=7, iss_rd=3; rs_count 1→0.
- Dispatch qi=4, then cdb ch1 tag=4 data=0x55 → entry issues the next cycle with iss_vi=0x55. Repeat with the CDB in the dispatch cycle (bypass) → same result.
- Fill all 16 entries with qi=9 → disp_ready=0, rs_count=16; a 17th disp_valid is ignored; broadcast tag 9 → 16 consecutive issues.
- Hold iss_ready=0 for 5 cycles with 3 ready entries → iss_* stable, rs_count=3 unchanged; release → one issue per cycle.
- With RS_AGE_ORDER_EN, entries are dispatched into slots 2, 0, 1 in that order, all ready → issue order is slot 2, 0, 1. Without the macro → 0, 1, 2.
- Assert wrong_commit with 5 busy entries, iss_valid=1 and disp_valid=1 → next cycle rs_count=0, iss_valid=0, nothing issues afterwards.

Source files
------------

// File: rtl/rs_age_ordered_pkg.sv
// Shared defaults for the age-ordered ALU reservation station.
// Age-ordered issue is enabled by defining RS_AGE_ORDER_EN.
package rs_age_ordered_pkg;

  localparam int RS_DEPTH_DEF = 16;
  localparam int TAG_W_DEF    = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int OP_W_DEF     = 7;
  localparam int CDB_N_DEF    = 2;

  // ROB tag 0 marks an operand whose value is already present.
  localparam int TAG_NONE     = 0;

endpackage

// File: rtl/rs_age_ordered_select.sv
// Issue picker: oldest ready entry when RS_AGE_ORDER_EN is defined,
// otherwise the lowest-index ready entry.
module rs_select
  import rs_age_ordered_pkg::*;
#(
  parameter int N = RS_DEPTH_DEF
) (
  input  logic [N-1:0]   ready,
  input  logic [N*N-1:0] older,
  output logic [N-1:0]   grant,
  output logic           any_ready
);

`ifdef RS_AGE_ORDER_EN
  // older[j*N+i] set means entry j was dispatched before entry i.
  always_comb begin
    grant     = '0;
    any_ready = |ready;
    for (int i = 0; i < N; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < N; j++) begin
        if (ready[j] && older[j*N+i]) grant[i] = 1'b0;
      end
    end
  end
`else
  logic found;
  logic older_unused;

  assign older_unused = ^older;

  always_comb begin
    grant     = '0;
    found     = 1'b0;
    any_ready = |ready;
    for (int i = 0; i < N; i++) begin
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_age_ordered.sv
// Reservation station for ALU-class ops with multi-channel CDB snooping.
// Define RS_AGE_ORDER_EN for oldest-ready-first issue via an age matrix.
module rs_age_ordered
  import rs_age_ordered_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int CDB_N    = CDB_N_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rdy,
  input  logic                         wrong_commit,
  input  logic [CDB_N-1:0]             cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]       cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]      cdb_data,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [DATA_W-1:0]            disp_pc,
  input  logic [DATA_W-1:0]            disp_imm,
  input  logic [DATA_W-1:0]            disp_vi,
  input  logic [DATA_W-1:0]            disp_vj,
  input  logic [TAG_W-1:0]             disp_qi,
  input  logic [TAG_W-1:0]             disp_qj,
  input  logic [TAG_W-1:0]             disp_rd,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [OP_W-1:0]              iss_op,
  output logic [DATA_W-1:0]            iss_vi,
  output logic [DATA_W-1:0]            iss_vj,
  output logic [DATA_W-1:0]            iss_imm,
  output logic [DATA_W-1:0]            iss_pc,
  output logic [TAG_W-1:0]             iss_rd,
  output logic [$clog2(RS_DEPTH):0]    rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_NONE);

  logic [RS_DEPTH-1:0]          busy;
  logic [OP_W-1:0]              e_op  [RS_DEPTH];
  logic [DATA_W-1:0]            e_pc  [RS_DEPTH];
  logic [DATA_W-1:0]            e_imm [RS_DEPTH];
  logic [DATA_W-1:0]            e_vi  [RS_DEPTH];
  logic [DATA_W-1:0]            e_vj  [RS_DEPTH];
  logic [TAG_W-1:0]             e_qi  [RS_DEPTH];
  logic [TAG_W-1:0]             e_qj  [RS_DEPTH];
  logic [TAG_W-1:0]             e_rd  [RS_DEPTH];
  logic [RS_DEPTH*RS_DEPTH-1:0] older;

  logic [RS_DEPTH-1:0] ready_vec, grant, busy_nxt;
  logic                any_ready, free_found, load, do_issue, do_disp;
  logic [IDX_W-1:0]    free_idx, sel_idx;
  logic [DATA_W-1:0]   cap_vi, cap_vj;
  logic [TAG_W-1:0]    cap_qi, cap_qj;

  // Resolve one operand against all CDB channels; the lowest channel wins.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0]  q,
                                                    input logic [DATA_W-1:0] v);
    logic [TAG_W+DATA_W-1:0] r;
    r = {q, v};
    for (int k = CDB_N-1; k >= 0; k--) begin
      if (cdb_valid[k] && q != TAG_Z && cdb_tag[k*TAG_W +: TAG_W] == q)
        r = {TAG_Z, cdb_data[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++)
      ready_vec[i] = busy[i] && (e_qi[i] == TAG_Z) && (e_qj[i] == TAG_Z);
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (grant[i]) sel_idx = IDX_W'(i);
  end

  rs_select #(.N(RS_DEPTH)) u_select (
    .ready     (ready_vec),
    .older     (older),
    .grant     (grant),
    .any_ready (any_ready)
  );

  assign disp_ready       = free_found && !wrong_commit;
  assign load             = !iss_valid || iss_ready;
  assign do_issue         = rdy && load && any_ready;
  assign do_disp          = rdy && disp_valid && disp_ready;
  assign {cap_qi, cap_vi} = snoop(disp_qi, disp_vi);
  assign {cap_qj, cap_vj} = snoop(disp_qj, disp_vj);

  // A slot freed by issue stays unavailable to dispatch until next cycle.
  always_comb begin
    busy_nxt = busy & ~({RS_DEPTH{do_issue}} & grant);
    if (do_disp) busy_nxt[free_idx] = 1'b1;
  end

`ifdef RS_AGE_ORDER_EN
  always_ff @(posedge clk) begin
    if (!rst_n || wrong_commit) begin
      older <= '0;
    end else if (do_disp) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        for (int m = 0; m < RS_DEPTH; m++) begin
          if (m == int'(free_idx))      older[j*RS_DEPTH+m] <= busy[j];
          else if (j == int'(free_idx)) older[j*RS_DEPTH+m] <= 1'b0;
        end
      end
    end
  end
`else
  assign older = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || wrong_commit) begin
      busy      <= '0;
      rs_count  <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_vi    <= '0;
      iss_vj    <= '0;
      iss_imm   <= '0;
      iss_pc    <= '0;
      iss_rd    <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        e_qi[i] <= TAG_Z;
        e_qj[i] <= TAG_Z;
      end
    end else if (rdy) begin
      busy     <= busy_nxt;
      rs_count <= rs_count + CNT_W'(do_disp) - CNT_W'(do_issue);
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i]) begin
          {e_qi[i], e_vi[i]} <= snoop(e_qi[i], e_vi[i]);
          {e_qj[i], e_vj[i]} <= snoop(e_qj[i], e_vj[i]);
        end
      end
      if (do_disp) begin
        e_op[free_idx]  <= disp_op;
        e_pc[free_idx]  <= disp_pc;
        e_imm[free_idx] <= disp_imm;
        e_rd[free_idx]  <= disp_rd;
        e_vi[free_idx]  <= cap_vi;
        e_vj[free_idx]  <= cap_vj;
        e_qi[free_idx]  <= cap_qi;
        e_qj[free_idx]  <= cap_qj;
      end
      // Issue register holds its payload when nothing is ready.
      if (load) begin
        iss_valid <= any_ready;
        if (any_ready) begin
          iss_op  <= e_op[sel_idx];
          iss_vi  <= e_vi[sel_idx];
          iss_vj  <= e_vj[sel_idx];
          iss_imm <= e_imm[sel_idx];
          iss_pc  <= e_pc[sel_idx];
          iss_rd  <= e_rd[sel_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Randomised and directed bench for rs_age_ordered against a queue-level model.
// Issue-order expectations follow RS_AGE_ORDER_EN.
module tb_rs_age_ordered;

  localparam int RS_DEPTH = 16;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 7;
  localparam int CDB_N    = 2;
`ifdef RS_AGE_ORDER_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, rdy, wrong_commit, disp_valid, iss_ready;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic [OP_W-1:0]         disp_op;
  logic [DATA_W-1:0]       disp_pc, disp_imm, disp_vi, disp_vj;
  logic [TAG_W-1:0]        disp_qi, disp_qj, disp_rd;
  logic                    disp_ready, iss_valid;
  logic [OP_W-1:0]         iss_op;
  logic [DATA_W-1:0]       iss_vi, iss_vj, iss_imm, iss_pc;
  logic [TAG_W-1:0]        iss_rd;
  logic [4:0]              rs_count;

  always #5 clk = ~clk;

  rs_age_ordered #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                   .OP_W(OP_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .wrong_commit(wrong_commit),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_vi(disp_vi), .disp_vj(disp_vj),
    .disp_qi(disp_qi), .disp_qj(disp_qj), .disp_rd(disp_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vi(iss_vi), .iss_vj(iss_vj), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_rd(iss_rd), .rs_count(rs_count)
  );

  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [31:0] pc, imm, vi, vj;
    logic [4:0]  qi, qj, rd;
    int unsigned seq;
  } ent_t;

  ent_t        m_ent [RS_DEPTH];
  bit          m_iss_valid;
  logic [6:0]  m_iss_op;
  logic [31:0] m_iss_vi, m_iss_vj, m_iss_imm, m_iss_pc;
  logic [4:0]  m_iss_rd;
  int          m_cnt;
  int unsigned seq_ctr;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void resolve(input logic [4:0] q, input logic [31:0] v,
                                  output logic [4:0] qo, output logic [31:0] vo);
    qo = q;
    vo = v;
    if (q != 5'd0) begin
      for (int k = 0; k < CDB_N; k++) begin
        if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q) begin
          qo = 5'd0;
          vo = cdb_data[k*DATA_W +: DATA_W];
          break;
        end
      end
    end
  endfunction

  task automatic step_model();
    int pick, free;
    bit dok, ld;
    logic [4:0] nq;
    logic [31:0] nv;
    if (!rst_n || wrong_commit) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        m_ent[i].busy = 1'b0;
        m_ent[i].qi = '0;
        m_ent[i].qj = '0;
      end
      m_iss_valid = 1'b0; m_iss_op = '0; m_iss_vi = '0; m_iss_vj = '0;
      m_iss_imm = '0; m_iss_pc = '0; m_iss_rd = '0; m_cnt = 0;
    end else if (rdy) begin
      pick = -1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (m_ent[i].busy && m_ent[i].qi == 0 && m_ent[i].qj == 0) begin
          if (pick < 0) pick = i;
          else if (AGE && m_ent[i].seq < m_ent[pick].seq) pick = i;
        end
      end
      free = -1;
      for (int i = 0; i < RS_DEPTH; i++)
        if (!m_ent[i].busy && free < 0) free = i;
      dok = disp_valid && (m_cnt < RS_DEPTH);
      ld  = !m_iss_valid || iss_ready;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (m_ent[i].busy) begin
          resolve(m_ent[i].qi, m_ent[i].vi, nq, nv); m_ent[i].qi = nq; m_ent[i].vi = nv;
          resolve(m_ent[i].qj, m_ent[i].vj, nq, nv); m_ent[i].qj = nq; m_ent[i].vj = nv;
        end
      end
      if (ld) begin
        if (pick >= 0) begin
          m_iss_valid = 1'b1;
          m_iss_op = m_ent[pick].op;   m_iss_vi = m_ent[pick].vi;
          m_iss_vj = m_ent[pick].vj;   m_iss_imm = m_ent[pick].imm;
          m_iss_pc = m_ent[pick].pc;   m_iss_rd = m_ent[pick].rd;
          m_ent[pick].busy = 1'b0;
          m_cnt--;
        end else begin
          m_iss_valid = 1'b0;
        end
      end
      if (dok) begin
        m_ent[free].op = disp_op;   m_ent[free].pc = disp_pc;
        m_ent[free].imm = disp_imm; m_ent[free].rd = disp_rd;
        resolve(disp_qi, disp_vi, nq, nv); m_ent[free].qi = nq; m_ent[free].vi = nv;
        resolve(disp_qj, disp_vj, nq, nv); m_ent[free].qj = nq; m_ent[free].vj = nv;
        m_ent[free].seq = seq_ctr++;
        m_ent[free].busy = 1'b1;
        m_cnt++;
      end
    end
  endtask

  // One clock: check the combinational handshake, advance the model, compare registers.
  task automatic tick();
    #1;
    if (rst_n) chk("disp_ready", disp_ready, (m_cnt < RS_DEPTH) && !wrong_commit);
    step_model();
    @(posedge clk);
    #1;
    chk("iss_valid", iss_valid, m_iss_valid);
    chk("iss_op", iss_op, m_iss_op);
    chk("iss_vi", iss_vi, m_iss_vi);
    chk("iss_vj", iss_vj, m_iss_vj);
    chk("iss_imm", iss_imm, m_iss_imm);
    chk("iss_pc", iss_pc, m_iss_pc);
    chk("iss_rd", iss_rd, m_iss_rd);
    chk("rs_count", rs_count, m_cnt);
  endtask

  task automatic set_disp(input logic [4:0] qi, input logic [4:0] qj, input logic [4:0] rd,
                          input logic [31:0] vi, input logic [31:0] vj);
    disp_valid = 1'b1;
    disp_op = 7'h33;
    disp_pc = $urandom;
    disp_imm = $urandom;
    disp_qi = qi; disp_qj = qj; disp_rd = rd;
    disp_vi = vi; disp_vj = vj;
  endtask

  task automatic set_cdb(input int k, input logic [4:0] tag, input logic [31:0] data);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*TAG_W +: TAG_W] = tag;
    cdb_data[k*DATA_W +: DATA_W] = data;
  endtask

  task automatic idle(input int n);
    disp_valid = 1'b0;
    cdb_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    logic [4:0] got_rd [3];
    logic [4:0] exp_rd [3];
    checks = 0; errors = 0; seq_ctr = 0; m_cnt = 0;
    rst_n = 1'b0; rdy = 1'b1; wrong_commit = 1'b0; iss_ready = 1'b1;
    disp_valid = 1'b0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    disp_op = '0; disp_pc = '0; disp_imm = '0; disp_vi = '0; disp_vj = '0;
    disp_qi = '0; disp_qj = '0; disp_rd = '0;
    tick(); tick();
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_rs_count", rs_count, 0);
    chk("rst_iss_rd", iss_rd, 0);
    rst_n = 1'b1;

    // Back-to-back latency.
    set_disp(5'd0, 5'd0, 5'd3, 32'd5, 32'd7);
    tick();
    chk("lat_count1", rs_count, 1);
    chk("lat_valid_early", iss_valid, 0);
    idle(1);
    chk("lat_valid", iss_valid, 1);
    chk("lat_vi", iss_vi, 5);
    chk("lat_vj", iss_vj, 7);
    chk("lat_rd", iss_rd, 3);
    chk("lat_op", iss_op, 32'h33);
    chk("lat_count0", rs_count, 0);

    // Wake-up, dispatch bypass, and lowest-channel priority.
    set_disp(5'd4, 5'd0, 5'd5, 32'd0, 32'd1);
    tick();
    disp_valid = 1'b0; set_cdb(1, 5'd4, 32'h55);
    tick();
    chk("wake_not_yet", iss_valid, 0);
    idle(1);
    chk("wake_valid", iss_valid, 1);
    chk("wake_vi", iss_vi, 32'h55);
    set_disp(5'd4, 5'd0, 5'd6, 32'd0, 32'd1); set_cdb(1, 5'd4, 32'h55);
    tick();
    idle(1);
    chk("byp_vi", iss_vi, 32'h55);
    chk("byp_rd", iss_rd, 6);
    set_disp(5'd6, 5'd0, 5'd7, 32'd0, 32'd0);
    tick();
    disp_valid = 1'b0; set_cdb(0, 5'd6, 32'h11); set_cdb(1, 5'd6, 32'h22);
    tick();
    idle(1);
    chk("prio_vi", iss_vi, 32'h11);
    idle(2);

    // Fill, reject the overflow dispatch, then drain with one broadcast.
    for (int i = 0; i < RS_DEPTH; i++) begin
      set_disp(5'd9, 5'd0, 5'(i), $urandom, $urandom);
      tick();
    end
    chk("full_count", rs_count, 16);
    chk("full_ready", disp_ready, 0);
    set_disp(5'd0, 5'd0, 5'd31, 32'd1, 32'd1);
    tick();
    chk("full_ignored", rs_count, 16);
    disp_valid = 1'b0; set_cdb(0, 5'd9, 32'hABCD);
    tick();
    cdb_valid = '0;
    cnt = 0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      tick();
      if (iss_valid) cnt++;
    end
    chk("drain_issues", cnt, 16);
    chk("drain_count", rs_count, 0);
    idle(2);

    // Back-pressure holds the output and the occupancy.
    iss_ready = 1'b0;
    set_disp(5'd0, 5'd0, 5'd10, 32'd1, 32'd2);
    tick();
    idle(1);
    for (int i = 0; i < 3; i++) begin
      set_disp(5'd0, 5'd0, 5'(11 + i), $urandom, $urandom);
      tick();
    end
    idle(5);
    chk("bp_valid", iss_valid, 1);
    chk("bp_rd", iss_rd, 10);
    chk("bp_count", rs_count, 3);
    iss_ready = 1'b1;
    idle(1);
    chk("bp_rel_rd", iss_rd, 11);
    idle(4);

    // Issue order after out-of-order slot reuse: slots dispatched 2, 0, 1.
    set_disp(5'd10, 5'd0, 5'd20, 32'd0, 32'd0); tick();
    set_disp(5'd10, 5'd0, 5'd21, 32'd0, 32'd0); tick();
    set_disp(5'd11, 5'd0, 5'd22, 32'd0, 32'd0); tick();
    disp_valid = 1'b0; set_cdb(0, 5'd10, 32'h1);
    tick();
    idle(3);
    set_disp(5'd12, 5'd0, 5'd23, 32'd0, 32'd0); tick();
    set_disp(5'd12, 5'd0, 5'd24, 32'd0, 32'd0); tick();
    disp_valid = 1'b0; set_cdb(0, 5'd11, 32'h2); set_cdb(1, 5'd12, 32'h3);
    tick();
    cdb_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got_rd[i] = iss_rd;
    end
    if (AGE) begin
      exp_rd[0] = 5'd22; exp_rd[1] = 5'd23; exp_rd[2] = 5'd24;
    end else begin
      exp_rd[0] = 5'd23; exp_rd[1] = 5'd24; exp_rd[2] = 5'd22;
    end
    for (int i = 0; i < 3; i++) chk("order_rd", got_rd[i], exp_rd[i]);
    idle(2);

    // Flush with busy entries, a valid output and a dispatch attempt.
    iss_ready = 1'b0;
    set_disp(5'd0, 5'd0, 5'd1, 32'd1, 32'd1); tick();
    idle(1);
    for (int i = 0; i < 5; i++) begin
      set_disp(5'd13, 5'd0, 5'(2 + i), $urandom, $urandom);
      tick();
    end
    set_disp(5'd0, 5'd0, 5'd7, 32'd9, 32'd9);
    wrong_commit = 1'b1;
    #1;
    chk("flush_disp_ready", disp_ready, 0);
    tick();
    wrong_commit = 1'b0;
    chk("flush_count", rs_count, 0);
    chk("flush_valid", iss_valid, 0);
    iss_ready = 1'b1; disp_valid = 1'b0; set_cdb(0, 5'd13, 32'h7);
    tick();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (iss_valid) cnt++;
    end
    chk("flush_no_issue", cnt, 0);

    // Random traffic with small tag space to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      wrong_commit = ($urandom_range(0, 99) == 0);
      rdy          = ($urandom_range(0, 9) != 0);
      iss_ready    = ($urandom_range(0, 9) < 7);
      disp_valid   = ($urandom_range(0, 9) < 6);
      disp_op  = 7'($urandom); disp_pc = $urandom; disp_imm = $urandom;
      disp_vi  = $urandom;     disp_vj = $urandom;
      disp_qi  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      disp_qj  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
      disp_rd  = 5'($urandom);
      for (int k = 0; k < CDB_N; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_tag[k*TAG_W +: TAG_W] = 5'($urandom_range(0, 7));
        cdb_data[k*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
